// File: rtl/layer_compositor_if.sv
// rtl/layer_compositor_if.sv - pixel, frame-control and composited-output bundle for layer_compositor
//
// Purpose: groups every non-clock/reset signal of the compositor.
// Ports (by modport):
//   master : drives pix_en, pix_valid_in, frame_start, game_state, layer_en,
//            layer_color, bg_color; observes vga_data, pix_valid_out,
//            hit_layer, overlap.
//   slave  : the compositor side (directions reversed).
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 12,
    parameter int BG_W       = 16
);
    localparam int HIT_W = $clog2(NUM_LAYERS + 1);

    logic                          pix_en;
    logic                          pix_valid_in;
    logic                          frame_start;
    logic [1:0]                    game_state;
    logic [NUM_LAYERS-1:0]         layer_en;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_color;
    logic [BG_W-1:0]               bg_color;

    logic [COLOR_W-1:0]            vga_data;
    logic                          pix_valid_out;
    logic [HIT_W-1:0]              hit_layer;
    logic [NUM_LAYERS-1:0]         overlap;

    modport master (
        output pix_en, pix_valid_in, frame_start, game_state,
               layer_en, layer_color, bg_color,
        input  vga_data, pix_valid_out, hit_layer, overlap
    );

    modport slave (
        input  pix_en, pix_valid_in, frame_start, game_state,
               layer_en, layer_color, bg_color,
        output vga_data, pix_valid_out, hit_layer, overlap
    );
endinterface

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - N-layer priority sprite compositor with game-state modes, blink and overlap flags
//
// Purpose: merges NUM_LAYERS sprite layers (layer 0 highest priority) over a
// background through a 2-stage pixel pipeline advanced by pix_en. The game
// mode is sampled only on frame_start. GAME_OVER blinks sprites off every
// BLINK_FRAMES frames, and per-layer overlap flags are latched per frame.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : layer_compositor_if.slave
//          in  pix_en, pix_valid_in, frame_start, game_state[1:0],
//              layer_en[N], layer_color[N*COLOR_W], bg_color[BG_W]
//          out vga_data[COLOR_W], pix_valid_out, hit_layer, overlap[N]
module layer_compositor #(
    parameter int                  NUM_LAYERS    = 4,
    parameter int                  COLOR_W       = 12,
    parameter int                  BG_W          = 16,
    parameter logic [COLOR_W-1:0]  KEY_COLOR     = 12'h000,
    parameter logic [BG_W-1:0]     BG_KEY        = 16'hFFFF,
    parameter int                  BLINK_FRAMES  = 16,
    parameter logic [COLOR_W-1:0]  INIT_COLOR    = 12'hF00,
    parameter logic [COLOR_W-1:0]  SUCCESS_COLOR = 12'h00F
) (
    input  logic               clk,
    input  logic               rst,
    layer_compositor_if.slave  bus
);

    localparam int                HIT_W    = $clog2(NUM_LAYERS + 1);
    localparam int                BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [HIT_W-1:0]  NO_HIT   = HIT_W'(NUM_LAYERS);

    typedef enum logic [1:0] {
        MODE_INITIAL = 2'b00,
        MODE_RUNNING = 2'b01,
        MODE_OVER    = 2'b10,
        MODE_SUCCESS = 2'b11
    } mode_t;

    // Frame-synchronous state
    mode_t              mode_q, mode_d;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               blk_phase_q, blk_phase_d;

    // Stage-1 registers
    logic [NUM_LAYERS-1:0] s1_mask;
    logic [HIT_W-1:0]      s1_idx;
    logic [COLOR_W-1:0]    s1_color;
    logic [BG_W-1:0]       s1_bg;
    logic                  s1_valid;

    // Overlap accumulator for the frame in progress
    logic [NUM_LAYERS-1:0] ovl_acc;

    // Stage-1 combinational decode
    logic [NUM_LAYERS-1:0] opaque;
    logic [HIT_W-1:0]      win_idx;
    logic [COLOR_W-1:0]    win_color;
    logic [NUM_LAYERS-1:0] ovl_hits;
    logic                  acc_qual;

    // Stage-2 combinational colour
    logic [COLOR_W-1:0]    bg_rule;
    logic [COLOR_W-1:0]    sprite_rule;
    logic [COLOR_W-1:0]    out_color;

    // Walking from the lowest priority upward lets the last opaque layer
    // seen (the lowest index) overwrite the winner.
    always_comb begin
        opaque    = '0;
        win_idx   = NO_HIT;
        win_color = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (bus.layer_en[i] && (bus.layer_color[i*COLOR_W +: COLOR_W] != KEY_COLOR)) begin
                opaque[i] = 1'b1;
                win_idx   = HIT_W'(i);
                win_color = bus.layer_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // A layer is flagged only when some *other* layer is opaque on the same pixel.
    always_comb begin
        ovl_hits = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            ovl_hits[i] = opaque[i] && ((opaque & ~(NUM_LAYERS'(1) << i)) != '0);
        end
    end

    assign acc_qual = (mode_q == MODE_RUNNING) && bus.pix_en && bus.pix_valid_in;

    // Mode and blink next-state; everything moves only on frame_start.
    always_comb begin
        mode_d      = mode_q;
        blk_cnt_d   = blk_cnt_q;
        blk_phase_d = blk_phase_q;
        if (bus.frame_start) begin
            mode_d = mode_t'(bus.game_state);
            if (mode_t'(bus.game_state) == MODE_OVER) begin
                if (blk_cnt_q == BLK_LAST) begin
                    blk_cnt_d   = '0;
                    blk_phase_d = ~blk_phase_q;
                end else begin
                    blk_cnt_d = blk_cnt_q + BLK_W'(1);
                end
            end else begin
                blk_cnt_d   = '0;
                blk_phase_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= MODE_INITIAL;
            blk_cnt_q   <= '0;
            blk_phase_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            blk_cnt_q   <= blk_cnt_d;
            blk_phase_q <= blk_phase_d;
        end
    end

    // Stage-2 colour selection uses the mode register as it stands before
    // this edge, so a frame_start coinciding with pix_en affects the next pixel.
    always_comb begin
        bg_rule     = (s1_bg == BG_KEY) ? '0 : s1_bg[BG_W-1 -: COLOR_W];
        sprite_rule = (|s1_mask) ? s1_color : bg_rule;
        out_color   = '0;
        if (s1_valid) begin
            unique case (mode_q)
                MODE_INITIAL: out_color = INIT_COLOR;
                MODE_SUCCESS: out_color = SUCCESS_COLOR;
                MODE_RUNNING: out_color = sprite_rule;
                MODE_OVER:    out_color = blk_phase_q ? bg_rule : sprite_rule;
                default:      out_color = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_mask           <= '0;
            s1_idx            <= NO_HIT;
            s1_color          <= '0;
            s1_bg             <= '0;
            s1_valid          <= 1'b0;
            bus.vga_data      <= '0;
            bus.pix_valid_out <= 1'b0;
            bus.hit_layer     <= NO_HIT;
        end else if (bus.pix_en) begin
            s1_mask           <= opaque;
            s1_idx            <= win_idx;
            s1_color          <= win_color;
            s1_bg             <= bus.bg_color;
            s1_valid          <= bus.pix_valid_in;
            bus.vga_data      <= out_color;
            bus.pix_valid_out <= s1_valid;
            bus.hit_layer     <= s1_idx;
        end
    end

    // On frame_start the finished frame is published and the accumulator
    // restarts with whatever the coinciding pixel contributes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovl_acc     <= '0;
            bus.overlap <= '0;
        end else if (bus.frame_start) begin
            bus.overlap <= ovl_acc;
            ovl_acc     <= acc_qual ? ovl_hits : '0;
        end else if (acc_qual) begin
            ovl_acc <= ovl_acc | ovl_hits;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - directed self-checking bench for layer_compositor
module tb_layer_compositor;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    layer_compositor_if #(.NUM_LAYERS(4), .COLOR_W(12), .BG_W(16)) bus ();

    layer_compositor #(
        .NUM_LAYERS   (4),
        .COLOR_W      (12),
        .BG_W         (16),
        .KEY_COLOR    (12'h000),
        .BG_KEY       (16'hFFFF),
        .BLINK_FRAMES (2),
        .INIT_COLOR   (12'hF00),
        .SUCCESS_COLOR(12'h00F)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_px(input logic [3:0] en, input logic [11:0] c0, input logic [11:0] c1,
                          input logic [11:0] c2, input logic [11:0] c3,
                          input logic [15:0] bg, input logic v);
        bus.layer_en     = en;
        bus.layer_color  = {c3, c2, c1, c0};
        bus.bg_color     = bg;
        bus.pix_valid_in = v;
    endtask

    task automatic frame_pulse(input logic [1:0] gs);
        bus.game_state  = gs;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.pix_en      = 1'b1;
        bus.frame_start = 1'b0;
        bus.game_state  = 2'b00;
        set_px(4'hF, 12'h000, 12'h000, 12'h000, 12'h000, 16'h0000, 1'b0);
        repeat (3) tick();
        check("rst_vga", 32'(bus.vga_data), 32'h000);
        check("rst_pv",  32'(bus.pix_valid_out), 32'h0);
        check("rst_hit", 32'(bus.hit_layer), 32'd4);
        check("rst_ovl", 32'(bus.overlap), 32'h0);

        // First frame in RUNNING: layer1 wins, two strobes of latency
        rst = 1'b1;
        set_px(4'hF, 12'h000, 12'h0F0, 12'h000, 12'h000, 16'h1234, 1'b1);
        frame_pulse(2'b01);
        check("lat1_pv",  32'(bus.pix_valid_out), 32'h0);
        check("lat1_vga", 32'(bus.vga_data), 32'h000);
        tick();
        check("run_vga", 32'(bus.vga_data), 32'h0F0);
        check("run_hit", 32'(bus.hit_layer), 32'd1);
        check("run_pv",  32'(bus.pix_valid_out), 32'h1);

        // Background key and background passthrough
        set_px(4'hF, 12'h000, 12'h000, 12'h000, 12'h000, 16'hFFFF, 1'b1);
        tick(); tick();
        check("key_vga", 32'(bus.vga_data), 32'h000);
        check("key_hit", 32'(bus.hit_layer), 32'd4);
        bus.bg_color = 16'hABCD;
        tick(); tick();
        check("bg_vga", 32'(bus.vga_data), 32'hABC);
        check("bg_hit", 32'(bus.hit_layer), 32'd4);

        // Layers 0 and 2 overlap on one pixel
        set_px(4'hF, 12'h00F, 12'h000, 12'h0F0, 12'h000, 16'hABCD, 1'b1);
        tick();
        set_px(4'hF, 12'h000, 12'h000, 12'h000, 12'h000, 16'hABCD, 1'b1);
        tick();
        check("ovl_pix_vga", 32'(bus.vga_data), 32'h00F);
        check("ovl_pix_hit", 32'(bus.hit_layer), 32'd0);
        frame_pulse(2'b01);
        check("ovl_latch", 32'(bus.overlap), 32'b0101);

        // Overlap on the frame_start pixel belongs to the new frame
        set_px(4'hF, 12'h000, 12'h0F0, 12'h000, 12'hF00, 16'hABCD, 1'b1);
        frame_pulse(2'b01);
        check("ovl_clear", 32'(bus.overlap), 32'b0000);
        set_px(4'hF, 12'h000, 12'h000, 12'h000, 12'h000, 16'hABCD, 1'b1);
        tick();
        frame_pulse(2'b01);
        check("ovl_new", 32'(bus.overlap), 32'b1010);

        // Mid-frame switch to OVER has no effect until frame_start
        set_px(4'hF, 12'hF0F, 12'h000, 12'h000, 12'h000, 16'h1234, 1'b1);
        bus.game_state = 2'b10;
        tick(); tick();
        check("mid_vga", 32'(bus.vga_data), 32'hF0F);
        frame_pulse(2'b10);
        tick();
        check("over1_vga", 32'(bus.vga_data), 32'hF0F);
        frame_pulse(2'b10);
        tick();
        check("over2_vga", 32'(bus.vga_data), 32'h123);
        check("over2_hit", 32'(bus.hit_layer), 32'd0);
        frame_pulse(2'b10);
        tick();
        check("over3_vga", 32'(bus.vga_data), 32'h123);
        frame_pulse(2'b10);
        tick();
        check("over4_vga", 32'(bus.vga_data), 32'hF0F);

        // pix_en stall holds the pipeline
        frame_pulse(2'b01);
        set_px(4'hF, 12'h000, 12'h000, 12'h000, 12'h0F0, 16'h1234, 1'b1);
        tick(); tick();
        check("pre_vga", 32'(bus.vga_data), 32'h0F0);
        check("pre_hit", 32'(bus.hit_layer), 32'd3);
        set_px(4'hF, 12'h000, 12'h000, 12'h000, 12'h000, 16'h5678, 1'b0);
        bus.pix_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_vga", 32'(bus.vga_data), 32'h0F0);
            check("stall_hit", 32'(bus.hit_layer), 32'd3);
            check("stall_pv",  32'(bus.pix_valid_out), 32'h1);
        end
        bus.pix_en = 1'b1;
        tick();
        check("res1_vga", 32'(bus.vga_data), 32'h0F0);
        tick();
        check("res2_vga", 32'(bus.vga_data), 32'h000);
        check("res2_pv",  32'(bus.pix_valid_out), 32'h0);
        check("res2_hit", 32'(bus.hit_layer), 32'd4);

        // Solid-fill modes
        set_px(4'hF, 12'h000, 12'h000, 12'h000, 12'h000, 16'h5678, 1'b1);
        frame_pulse(2'b00);
        tick();
        check("init_vga", 32'(bus.vga_data), 32'hF00);
        bus.pix_valid_in = 1'b0;
        tick(); tick();
        check("init_inv", 32'(bus.vga_data), 32'h000);
        frame_pulse(2'b11);
        bus.pix_valid_in = 1'b1;
        tick(); tick();
        check("succ_vga", 32'(bus.vga_data), 32'h00F);
        bus.pix_valid_in = 1'b0;
        tick(); tick();
        check("succ_inv", 32'(bus.vga_data), 32'h000);
        bus.pix_valid_in = 1'b1;
        tick(); tick();

        // Asynchronous reset mid-frame
        #2 rst = 1'b0;
        #1;
        check("arst_vga", 32'(bus.vga_data), 32'h000);
        check("arst_pv",  32'(bus.pix_valid_out), 32'h0);
        check("arst_hit", 32'(bus.hit_layer), 32'd4);
        check("arst_ovl", 32'(bus.overlap), 32'h0);
        tick();
        rst = 1'b1;
        tick(); tick();
        check("post_rst_vga", 32'(bus.vga_data), 32'hF00);
        frame_pulse(2'b01);
        tick();
        check("post_run_vga", 32'(bus.vga_data), 32'h567);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
Parametrised pixel compositor that merges N sprite layers over a background in front of VGA_driver. Generalises the fixed mario/kong/queue/barrel priority mux to NUM_LAYERS channels, with a 2-stage pixel pipeline and frame-synchronous game-state modes. It adds two behaviours the fixed mux lacks: a blink effect on game over and per-layer sprite-overlap (collision) flags latched once per frame.

Parameters:
NUM_LAYERS, 4, number of sprite layers; layer 0 has highest priority.
COLOR_W, 12, sprite and output colour width (RGB444).
BG_W, 16, background pixel width; output uses bg_color[BG_W-1 -: COLOR_W].
KEY_COLOR, 12'h000, sprite transparent colour.
BG_KEY, 16'hFFFF, background value rendered as black.
BLINK_FRAMES, 16, frames per blink half-period in GAME_OVER; minimum 1.
INIT_COLOR, 12'hF00, solid fill in GAME_INITIAL.
SUCCESS_COLOR, 12'h00F, solid fill in GAME_SUCCESS.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
pix_en  in  1  pixel strobe; pipeline advances only when 1
pix_valid_in  in  1  current pixel is inside the visible area
frame_start  in  1  one-cycle pulse at start of frame
game_state  in  2  00 INITIAL, 01 RUNNING, 10 OVER, 11 SUCCESS
layer_en  in  NUM_LAYERS  per-layer enable mask
layer_color  in  NUM_LAYERS*COLOR_W  layer i at [i*COLOR_W +: COLOR_W]
bg_color  in  BG_W  background pixel
vga_data  out  COLOR_W  composited pixel
pix_valid_out  out  1  pix_valid_in delayed through the pipeline
hit_layer  out  $clog2(NUM_LAYERS+1)  index of the winning layer; NUM_LAYERS when background wins
overlap  out  NUM_LAYERS  bit i set if layer i overlapped any other layer during the previous frame

Behaviour:
- Reset (rst=0, async): vga_data=0, pix_valid_out=0, hit_layer=NUM_LAYERS, overlap=0, mode_q=INITIAL, blink counter=0, blink phase=0, overlap accumulator=0.
- Layer i is opaque when layer_en[i]=1 and its colour != KEY_COLOR.
- Stage 1 (on pix_en):
  - Register the opaque mask.
  - Register the lowest-index opaque layer and its colour.
  - Register bg_color and pix_valid_in.
- Stage 2 (on pix_en): produce the output. Total latency is 2 pix_en strobes. When pix_en=0, all pipeline registers hold.
- mode_q loads game_state only on a cycle with frame_start=1. Mid-frame changes to game_state have no effect until the next frame_start.
- Output by mode_q:
  - INITIAL: INIT_COLOR.
  - SUCCESS: SUCCESS_COLOR.
  - RUNNING: winning sprite colour if any layer is opaque. Otherwise 0 when bg==BG_KEY, else the upper COLOR_W bits of bg.
  - OVER: background rule only when blink phase=1. When blink phase=0, same as RUNNING.
- When pix_valid (stage 2) is 0, vga_data=0 regardless of mode.
- hit_layer follows the stage-2 winner in all modes. It is NUM_LAYERS when no layer is opaque.
- Blink:
  - On each frame_start with the newly loaded mode=OVER, the counter increments.
  - When the counter reaches BLINK_FRAMES-1, it wraps to 0 and the phase toggles.
  - On a frame_start loading any other mode, counter and phase clear to 0.
- Overlap accumulation:
  - Only in mode_q=RUNNING, on a stage-1 pixel with pix_valid=1 and pix_en=1.
  - For every opaque layer i, if at least one other layer is also opaque, set acc[i].
- Frame boundary for overlap:
  - On frame_start, overlap <= acc, and acc clears.
  - If a qualifying pixel coincides with frame_start, it is counted into the new (cleared) accumulator, not the latched value.
- Simultaneous frame_start and pix_en: both actions occur on that edge. The pixel in stage 2 uses the old mode_q; the new mode applies from the next edge.
- Async reset mid-frame aborts everything. Output stays INIT_COLOR-mode (mode_q=INITIAL) until the first frame_start after release.

Test Plan:
- Reset, then frame_start with game_state=01, pix_en held 1, layer0=12'h000, layer1=12'h0F0, bg=16'h1234 -> two strobes later vga_data=12'h0F0, hit_layer=1.
- RUNNING, all layers 12'h000, bg=16'hFFFF -> vga_data=12'h000, hit_layer=4; bg=16'hABCD -> vga_data=12'hABC.
- Layers 0 and 2 opaque for one valid pixel, then frame_start -> overlap=4'b0101. A following frame with no overlap -> overlap=4'b0000 after the next frame_start.
- game_state changed 01->10 mid-frame -> output unchanged until frame_start. With BLINK_FRAMES=2: frames alternate in pairs sprite-visible/background-only (layer0=12'hF0F shown, then hidden).
- pix_en low for 3 cycles mid-stream -> vga_data, hit_layer and pix_valid_out hold. Output resumes 2 strobes after new input.
- game_state=00 and 11 after frame_start -> vga_data=12'hF00 / 12'h00F for valid pixels and 0 when pix_valid_in=0. Assert rst low mid-frame -> all outputs at reset values immediately.
